// File: rtl/lite_v2.sv
// lite_v2: two-operand datapath between decode and writeback of the lite core.
// Accepts opcode/d1/d2 over a valid/ready handshake, computes pass/add/sub/
// logic ops in one cycle or an unsigned shift-add multiply over WIDTH cycles,
// and holds res/carry/zero under a valid/ready output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   opcode/d1/d2 valid
//   in_ready   block can accept (IDLE and not in reset)
//   opcode     operation select
//   d1, d2     operands A and B
//   res        registered result
//   res_valid  res/carry/zero valid
//   res_ready  consumer accepts the result
//   carry      registered carry / borrow / multiply-overflow flag
//   zero       registered, set when res == 0
module lite_v2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             carry,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [2:0] OP_PASS_A = 3'b000;
  localparam logic [2:0] OP_PASS_B = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;
  localparam logic [2:0] OP_MUL    = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Datapath registers
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Control strobes from the output decode
  logic accept;
  logic mul_start;
  logic alu_load;
  logic mul_step;
  logic mul_last;

  // Single-cycle ALU results
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  // Multiplier step: conditional add of the shifted multiplicand
  logic [PW-1:0]    acc_step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (opcode == OP_MUL) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (mul_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / strobe decode; in_ready is gated by rst so nothing is accepted in reset
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    mul_step  = 1'b0;
    unique case (state_q)
      S_IDLE:  in_ready  = ~rst;
      S_BUSY:  mul_step  = 1'b1;
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
    accept    = in_valid & in_ready;
    mul_start = accept & (opcode == OP_MUL);
    alu_load  = accept & (opcode != OP_MUL);
    // Counter starts at WIDTH; the step seen with cnt==1 is the last multiplier bit
    mul_last  = mul_step & (cnt_q == CW'(1));
  end

  // Single-cycle operations
  always_comb begin
    sum_ext   = {1'b0, d1} + {1'b0, d2};
    // Top bit of the extended difference is the borrow (d1 < d2 unsigned)
    diff_ext  = {1'b0, d1} - {1'b0, d2};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OP_PASS_A: alu_res = d1;
      OP_PASS_B: alu_res = d2;
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
      end
      OP_AND:    alu_res = d1 & d2;
      OP_OR:     alu_res = d1 | d2;
      OP_XOR:    alu_res = d1 ^ d2;
      OP_MUL:    alu_res = '0;
    endcase
  end

  // Multiplier and result next-state
  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    if (mul_start) begin
      acc_d    = '0;
      mcand_d  = PW'(d1);
      mplier_d = d2;
      cnt_d    = CW'(WIDTH);
    end else if (mul_step) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end

    if (alu_load) begin
      res_d   = alu_res;
      carry_d = alu_carry;
      zero_d  = (alu_res == '0);
    end else if (mul_last) begin
      // Final step's sum is used directly so the result lands on the same edge
      res_d   = acc_step[WIDTH-1:0];
      carry_d = |acc_step[PW-1:WIDTH];
      zero_d  = (acc_step[WIDTH-1:0] == '0);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      res_q    <= res_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign res   = res_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_lite_v2.sv
// Scoreboard bench for lite_v2: WIDTH=8 and WIDTH=16 instances, directed vectors.
module tb_lite_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v8_in_valid, v8_in_ready, v8_res_valid, v8_res_ready, v8_carry, v8_zero;
  logic [2:0]  v8_opcode;
  logic [7:0]  v8_d1, v8_d2, v8_res;

  logic        v16_in_valid, v16_in_ready, v16_res_valid, v16_res_ready, v16_carry, v16_zero;
  logic [2:0]  v16_opcode;
  logic [15:0] v16_d1, v16_d2, v16_res;

  lite_v2 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .opcode(v8_opcode), .d1(v8_d1), .d2(v8_d2),
    .res(v8_res), .res_valid(v8_res_valid), .res_ready(v8_res_ready),
    .carry(v8_carry), .zero(v8_zero)
  );

  lite_v2 #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst),
    .in_valid(v16_in_valid), .in_ready(v16_in_ready),
    .opcode(v16_opcode), .d1(v16_d1), .d2(v16_d2),
    .res(v16_res), .res_valid(v16_res_valid), .res_ready(v16_res_ready),
    .carry(v16_carry), .zero(v16_zero)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        carry;
    logic        zero;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance: compare on each new result presentation
  logic prev8 = 1'b0;
  always @(negedge clk) begin : mon8
    exp_t e;
    if (v8_res_valid && !prev8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w8_unexpected_result: got res 0x%0h with no pending operation", v8_res);
      end else begin
        e = q8.pop_front();
        chk("w8_res",     32'(v8_res),        32'(e.res));
        chk("w8_carry",   32'(v8_carry),      32'(e.carry));
        chk("w8_zero",    32'(v8_zero),       32'(e.zero));
        chk("w8_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
      end
    end
    prev8 = v8_res_valid;
  end

  // Monitor for the 16-bit instance
  logic prev16 = 1'b0;
  always @(negedge clk) begin : mon16
    exp_t e;
    if (v16_res_valid && !prev16) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w16_unexpected_result: got res 0x%0h with no pending operation", v16_res);
      end else begin
        e = q16.pop_front();
        chk("w16_res",     32'(v16_res),        32'(e.res));
        chk("w16_carry",   32'(v16_carry),      32'(e.carry));
        chk("w16_zero",    32'(v16_zero),       32'(e.zero));
        chk("w16_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
      end
    end
    prev16 = v16_res_valid;
  end

  function automatic logic rdy(input int w);
    return (w == 8) ? v8_in_ready : v16_in_ready;
  endfunction

  // Drive one operation, wait (bounded) for acceptance, push the expectation
  task automatic issue(input int w, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ec, input logic ez, input bit push);
    exp_t e;
    int   k;
    @(negedge clk);
    if (w == 8) begin
      v8_opcode = op; v8_d1 = a[7:0]; v8_d2 = b[7:0]; v8_in_valid = 1'b1;
    end else begin
      v16_opcode = op; v16_d1 = a; v16_d2 = b; v16_in_valid = 1'b1;
    end
    k = 0;
    while (!rdy(w) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!rdy(w)) begin
      n_checks++;
      n_fail++;
      $display("FAIL w%0d_accept_timeout: in_ready got 0 required 1", w);
    end else if (push) begin
      e.res = er; e.carry = ec; e.zero = ez; e.acc_cyc = cyc;
      e.lat = (op == 3'b111) ? w + 1 : 1;
      if (w == 8) q8.push_back(e);
      else        q16.push_back(e);
    end
    @(posedge clk);
    #1;
    if (w == 8) v8_in_valid = 1'b0;
    else        v16_in_valid = 1'b0;
  endtask

  // Wait (bounded) until both scoreboards are empty and both units idle
  task automatic drain();
    int k;
    k = 0;
    @(negedge clk);
    while ((q8.size() != 0 || q16.size() != 0 || !v8_in_ready || !v16_in_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (q8.size() != 0 || q16.size() != 0 || !v8_in_ready || !v16_in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: pending w8=%0d w16=%0d", q8.size(), q16.size());
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1;
    v8_in_valid = 1'b0;  v8_opcode = '0;  v8_d1 = '0;  v8_d2 = '0;  v8_res_ready = 1'b1;
    v16_in_valid = 1'b0; v16_opcode = '0; v16_d1 = '0; v16_d2 = '0; v16_res_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(v8_in_ready),  32'd0);
    chk("rst_res",       32'(v8_res),       32'd0);
    chk("rst_carry",     32'(v8_carry),     32'd0);
    chk("rst_zero",      32'(v8_zero),      32'd0);
    chk("rst_res_valid", 32'(v8_res_valid), 32'd0);
    chk("rst_w16_res",   32'(v16_res),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(v8_in_ready), 32'd1);

    // ADD 0xF0+0x20: carry out, then in_ready returns after the handoff
    issue(8, 3'b010, 16'h00F0, 16'h0020, 16'h0010, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("add_res_valid", 32'(v8_res_valid), 32'd1);
    @(negedge clk);
    chk("add_in_ready_back", 32'(v8_in_ready), 32'd1);

    issue(8, 3'b011, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1);
    issue(8, 3'b011, 16'h0003, 16'h0005, 16'h00FE, 1'b1, 1'b0, 1'b1);
    issue(8, 3'b110, 16'h00AA, 16'h00AA, 16'h0000, 1'b0, 1'b1, 1'b1);

    // MUL 0x13*0x11 = 0x143; in_ready stays low for the whole operation
    issue(8, 3'b111, 16'h0013, 16'h0011, 16'h0043, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("mul_in_ready_low", 32'(v8_in_ready), 32'd0);
      if (i < 8) chk("mul_res_valid_early", 32'(v8_res_valid), 32'd0);
    end
    issue(8, 3'b111, 16'h000F, 16'h000F, 16'h00E1, 1'b0, 1'b0, 1'b1);

    // Remaining opcodes and flag boundaries
    issue(8, 3'b000, 16'h003C, 16'h00C3, 16'h003C, 1'b0, 1'b0, 1'b1);
    issue(8, 3'b100, 16'h00F0, 16'h003C, 16'h0030, 1'b0, 1'b0, 1'b1);
    issue(8, 3'b101, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b1);
    issue(8, 3'b010, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(8, 3'b011, 16'h0000, 16'h0001, 16'h00FF, 1'b1, 1'b0, 1'b1);
    issue(8, 3'b111, 16'h00FF, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b1);
    issue(8, 3'b111, 16'h0000, 16'h0055, 16'h0000, 1'b0, 1'b1, 1'b1);
    drain();

    // Backpressure: result held, in_valid ignored while res_ready is low
    v8_res_ready = 1'b0;
    issue(8, 3'b001, 16'h0011, 16'h005A, 16'h005A, 1'b0, 1'b0, 1'b1);
    v8_in_valid = 1'b1; v8_opcode = 3'b010; v8_d1 = 8'h01; v8_d2 = 8'h02;
    repeat (5) begin
      @(negedge clk);
      chk("bp_res",       32'(v8_res),       32'h5A);
      chk("bp_res_valid", 32'(v8_res_valid), 32'd1);
      chk("bp_in_ready",  32'(v8_in_ready),  32'd0);
    end
    v8_in_valid = 1'b0;
    v8_res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready",  32'(v8_in_ready),  32'd1);
    chk("bp_release_res_valid", 32'(v8_res_valid), 32'd0);

    // Reset in the 4th BUSY cycle of a multiply aborts it
    issue(8, 3'b111, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_res",       32'(v8_res),       32'd0);
    chk("abort_carry",     32'(v8_carry),     32'd0);
    chk("abort_zero",      32'(v8_zero),      32'd0);
    chk("abort_res_valid", 32'(v8_res_valid), 32'd0);
    chk("abort_in_ready",  32'(v8_in_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_back", 32'(v8_in_ready), 32'd1);
    issue(8, 3'b010, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);

    // WIDTH=16 instance
    issue(16, 3'b111, 16'h1234, 16'h0010, 16'h2340, 1'b1, 1'b0, 1'b1);
    issue(16, 3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(16, 3'b011, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    issue(16, 3'b111, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    issue(16, 3'b110, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    issue(16, 3'b011, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    issue(16, 3'b100, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b1);
    issue(16, 3'b101, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1'b1);
    issue(16, 3'b001, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    issue(16, 3'b111, 16'h8000, 16'h0002, 16'h0000, 1'b1, 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lite_v2.md
# lite_v2

Parametrised successor to the two-operand registered datapath unit. It accepts an opcode and two WIDTH-bit operands over a valid/ready handshake and computes one of eight operations: pass-through, add, subtract, bitwise logic or multiply. Multiply is a multi-cycle shift-add. The result and status flags are held under a valid/ready output handshake. It sits between the instruction decode stage and the writeback stage of the lite core.

## Interface
- WIDTH, 8: operand and result width in bits (≥2).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  opcode/d1/d2 valid.
- in_ready  out  1  block can accept; high only in IDLE and only when rst is low.
- opcode  in  3  operation select (see Operation).
- d1  in  WIDTH  operand A.
- d2  in  WIDTH  operand B.
- res  out  WIDTH  registered result.
- res_valid  out  1  res/carry/zero valid.
- res_ready  in  1  consumer accepts the result.
- carry  out  1  registered carry/borrow/overflow flag.
- zero  out  1  registered, set when res == 0.

## Operation
- Accept happens when in_valid && in_ready. Operands and opcode are captured on the accept edge. Inputs are ignored at all other times.
- Opcodes:
  - 000 res=d1.
  - 001 res=d2.
  - 010 res=d1+d2, with carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 011 res=d1−d2 (mod 2^WIDTH), with carry = borrow (1 when d1<d2 unsigned).
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 MUL: res = low WIDTH bits of unsigned d1×d2; carry = 1 when the high WIDTH bits are nonzero.
- carry = 0 for opcodes 000, 001, 100, 101 and 110.
- zero = (res == 0) for every opcode, computed from the final result.
- State machine:
  - IDLE: in_ready=1. On an accept with opcode≠111, compute the result and load res/carry/zero, then go to DONE. On an accept with opcode 111, clear the 2·WIDTH-bit product accumulator, load the multiplier and counter, then go to BUSY.
  - BUSY: one multiplier bit per cycle, LSB first. Add the shifted multiplicand to the accumulator when the bit is 1. After WIDTH iterations, load res/carry/zero from the accumulator and go to DONE. in_ready=0.
  - DONE: res_valid=1. res, carry and zero are held stable. When res_ready=1, go to IDLE on that edge. in_ready=0, so a new operation is not accepted in the same cycle as the result handoff.
- The counter is ⌈log2(WIDTH+1)⌉ bits. The accumulator is 2·WIDTH bits and never overflows.

## Timing
- Reset values (one edge with rst=1): state=IDLE, res=0, carry=0, zero=0, res_valid=0, and accumulator/counter cleared.
- in_ready is 0 while rst=1 and 1 on the first cycle after rst is released.
- Reset mid-operation (BUSY or DONE) aborts the operation. No res_valid pulse and no partial result are produced after reset.
- Latency from accept edge to res_valid high:
  - Non-MUL: 1 cycle (res_valid is visible in the cycle after the accept).
  - MUL: WIDTH+1 cycles.
- Minimum issue interval: 2 cycles for non-MUL (accept, DONE with res_ready=1), and WIDTH+2 cycles for MUL.
- Backpressure:
  - res_valid stays high and res/carry/zero stay unchanged for as long as res_ready=0.
  - in_valid is ignored throughout.
- res_ready is ignored when res_valid=0.
- rst has priority over every handshake event on the same edge.

## Test plan
- Reset, then ADD with d1=0xF0, d2=0x20 (WIDTH=8) → one cycle after accept: res=0x10, carry=1, zero=0, res_valid=1. With res_ready=1, in_ready returns to 1 on the next cycle.
- SUB 0x05−0x05 → res=0x00, zero=1, carry=0. Then SUB 0x03−0x05 → res=0xFE, carry=1, zero=0. Then XOR 0xAA^0xAA → res=0x00, zero=1, carry=0.
- MUL 0x13×0x11 → res_valid asserts exactly 9 cycles after accept with res=0x43, carry=1, and in_ready is 0 throughout. Then MUL 0x0F×0x0F → res=0xE1, carry=0.
- Backpressure: PASS d2=0x5A, hold res_ready=0 for 5 cycles while driving in_valid=1 with other operands → res stays 0x5A, res_valid stays 1, no accept occurs. Release res_ready → return to IDLE.
- Reset mid-MUL: assert rst in the 4th BUSY cycle → next cycle res=0, carry=0, zero=0, res_valid=0. in_ready=1 after release, and a following ADD 0x01+0x01 yields res=0x02.
- Parameter sweep: WIDTH=4 and WIDTH=16 with random operands compared against a reference model, covering all 8 opcodes, latencies and flags.
